demux_cinco_out: RTL and testbench

- Registered 1-to-5 distributor: the write-side counterpart of the 5-input datapath selector. It takes one 32-bit value plus a 3-bit `controle` select and delivers the value to one of five destination channels.
- Each destination channel has a one-entry holding buffer with valid/ready handshake, so destinations that stall do not lose data.
- Sits between the ALU/memory result path and the five write-back consumers in the multicycle datapath.

---
 rtl/demux_cinco_out.sv | 77 +++++++
 tb/tb_demux_cinco_out.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/demux_cinco_out.sv
// Registered 1-to-5 distributor with a one-entry valid/ready buffer per channel.
// Out-of-range selects route to channel 0 and are flagged and counted.
module demux_cinco_out #(
  parameter int unsigned LARGURA      = 32,
  parameter int unsigned LARGURA_CONT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LARGURA-1:0]      entrada,
  input  logic [2:0]              controle,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  output logic [5*LARGURA-1:0]    saida,
  output logic [4:0]              saida_valida,
  input  logic [4:0]              saida_pronta,
  output logic                    sel_invalido,
  output logic [LARGURA_CONT-1:0] cont_invalidos
);

  logic [5*LARGURA-1:0]    dados_q, dados_d;
  logic [4:0]              valida_q, valida_d;
  logic                    invalido_q, invalido_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;

  logic [2:0] sel;
  logic       ctl_fora;
  logic       aceita;

  // Decode effective channel and the input handshake; depends only on the selected channel.
  always_comb begin
    ctl_fora       = (controle > 3'd4);
    sel            = ctl_fora ? 3'd0 : controle;
    entrada_pronta = !reset && (!valida_q[sel] || saida_pronta[sel]);
    aceita         = entrada_valida && entrada_pronta;
  end

  // Next-state: drains clear valid, a fill on the same channel overrides the drain.
  always_comb begin
    dados_d    = dados_q;
    valida_d   = valida_q & ~saida_pronta;
    invalido_d = invalido_q;
    cont_d     = cont_q;
    for (int i = 0; i < 5; i++) begin
      if (aceita && (sel == 3'(i))) begin
        dados_d[i*LARGURA +: LARGURA] = entrada;
        valida_d[i]                   = 1'b1;
      end
    end
    if (aceita && ctl_fora) begin
      invalido_d = 1'b1;
      if (!(&cont_q)) begin
        cont_d = cont_q + LARGURA_CONT'(1);
      end
    end
  end

  // State registers with synchronous reset; buffered words are discarded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dados_q    <= '0;
      valida_q   <= '0;
      invalido_q <= 1'b0;
      cont_q     <= '0;
    end else begin
      dados_q    <= dados_d;
      valida_q   <= valida_d;
      invalido_q <= invalido_d;
      cont_q     <= cont_d;
    end
  end

  assign saida          = dados_q;
  assign saida_valida   = valida_q;
  assign sel_invalido   = invalido_q;
  assign cont_invalidos = cont_q;

endmodule

// File: tb/tb_demux_cinco_out.sv
// Scoreboard bench for demux_cinco_out: per-channel expected-word queues are filled on
// accepted inputs and drained when the DUT hands a word to a ready consumer.
module tb_demux_cinco_out;

  localparam int unsigned L = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [L-1:0]   entrada;
  logic [2:0]     controle;
  logic           entrada_valida;
  logic           entrada_pronta;
  logic [5*L-1:0] saida;
  logic [4:0]     saida_valida;
  logic [4:0]     saida_pronta;
  logic           sel_invalido;
  logic [7:0]     cont_invalidos;

  demux_cinco_out #(.LARGURA(L), .LARGURA_CONT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .entrada        (entrada),
    .controle       (controle),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .saida          (saida),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta),
    .sel_invalido   (sel_invalido),
    .cont_invalidos (cont_invalidos)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected model state.
  logic [L-1:0] fila [5][$];
  int           m_cont = 0;
  logic         m_flag = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already set; checks, updates model, advances.
  task automatic ciclo();
    logic [2:0] s;
    logic       mp;
    logic [4:0] mv;
    #1;
    s  = (controle > 3'd4) ? 3'd0 : controle;
    mp = !reset && ((fila[s].size() == 0) || saida_pronta[s]);
    check("entrada_pronta", 32'(entrada_pronta), 32'(mp));
    if (!reset) begin
      for (int i = 0; i < 5; i++) mv[i] = (fila[i].size() != 0);
      check("saida_valida", 32'(saida_valida), 32'(mv));
      check("sel_invalido", 32'(sel_invalido), 32'(m_flag));
      check("cont_invalidos", 32'(cont_invalidos), 32'(m_cont));
      for (int i = 0; i < 5; i++) begin
        if (fila[i].size() != 0) begin
          check($sformatf("saida_ch%0d", i), saida[i*L +: L], fila[i][0]);
          if (saida_pronta[i]) void'(fila[i].pop_front());
        end
      end
    end
    if (reset) begin
      for (int i = 0; i < 5; i++) fila[i].delete();
      m_cont = 0;
      m_flag = 1'b0;
    end else if (entrada_valida && mp) begin
      fila[s].push_back(entrada);
      if (controle > 3'd4) begin
        m_flag = 1'b1;
        if (m_cont < 255) m_cont++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic envia(input logic [2:0] c, input logic [L-1:0] d);
    entrada_valida = 1'b1;
    controle       = c;
    entrada        = d;
    ciclo();
  endtask

  task automatic ocioso(input int n);
    entrada_valida = 1'b0;
    controle       = 3'($urandom_range(0, 7));
    entrada        = $urandom;
    for (int k = 0; k < n; k++) ciclo();
  endtask

  initial begin
    reset          = 1'b1;
    entrada        = '0;
    controle       = '0;
    entrada_valida = 1'b0;
    saida_pronta   = 5'h1f;
    @(negedge clk);
    ciclo();
    ciclo();
    reset = 1'b0;
    ocioso(2);

    // Basic route to channel 3.
    envia(3'd3, 32'hDEADBEEF);
    ocioso(2);

    // Backpressure on channel 2, then release with a same-cycle refill.
    saida_pronta = 5'h1b;
    envia(3'd2, 32'h11111111);
    envia(3'd2, 32'h22222222);
    envia(3'd2, 32'h22222222);
    saida_pronta = 5'h1f;
    envia(3'd2, 32'h22222222);
    ocioso(2);

    // Channel 0 stalled and full, channel 4 still accepts.
    saida_pronta = 5'h1e;
    envia(3'd0, 32'h0BADF00D);
    envia(3'd4, 32'hA5A5A5A5);
    ocioso(2);
    saida_pronta = 5'h1f;
    ocioso(2);

    // Invalid selects route to channel 0 and are counted.
    envia(3'd7, 32'h1);
    envia(3'd7, 32'h2);
    envia(3'd7, 32'h3);
    ocioso(1);
    envia(3'd5, 32'h4);
    envia(3'd6, 32'h5);
    ocioso(1);

    // Stalled invalid request is not counted until accepted.
    saida_pronta = 5'h1e;
    envia(3'd7, 32'h6);
    envia(3'd7, 32'h7);
    envia(3'd7, 32'h7);
    saida_pronta = 5'h1f;
    ocioso(2);

    // Counter saturation.
    for (int k = 0; k < 260; k++) envia(3'd7, $urandom);
    ocioso(1);

    // Reset in mid-operation with channels 1 and 4 full and stalled.
    saida_pronta = 5'h0d;
    envia(3'd1, 32'hCAFE0001);
    envia(3'd4, 32'hCAFE0004);
    ocioso(1);
    reset = 1'b1;
    ocioso(1);
    reset = 1'b0;
    envia(3'd1, 32'h600DF00D);
    ocioso(1);
    saida_pronta = 5'h1f;
    ocioso(2);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      saida_pronta   = 5'($urandom);
      entrada_valida = 1'($urandom);
      controle       = 3'($urandom_range(0, 7));
      entrada        = $urandom;
      ciclo();
    end
    saida_pronta = 5'h1f;
    ocioso(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
